uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver, the receive-side counterpart of the team's uart transmitter; runs in the clk_50m domain.
- Oversamples the asynchronous rx line using an external baud-tick enable at OVERSAMPLE x baud, and captures bytes LSB first.
- Presents each byte with a sticky ready flag, cleared by the consumer.
- Flags framing errors and overruns.

Parameters:
- OVERSAMPLE, 16: clken ticks per bit period; must be even and >= 4.

Ports:
- clk_50m  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clken  input  1  oversample tick, 1-cycle pulse at OVERSAMPLE x baud (for example, every 27 clocks gives 115200 baud at x16).
- rx  input  1  serial line, asynchronous, idles high.
- rdy_clr  input  1  consumer acknowledge; clears rdy.
- dout  output  8  last received byte.
- rdy  output  1  sticky "dout holds an unread byte".
- rx_busy  output  1  high while a frame is in progress.
- frame_err  output  1  1-cycle pulse: stop bit sampled low.
- overrun  output  1  1-cycle pulse: a byte completed while rdy was already 1.
- parity_err  output  1  1-cycle pulse: parity mismatch; tied 0 when the parity feature is compiled out.

Behaviour:
- Reset values (asynchronous, rst_n=0): dout=8'h00; rdy, rx_busy, frame_err, overrun and parity_err all 0; synchronizer flops=1; state=IDLE; sample counter=0; bit index=0.
- Synchronizer: rx passes through 2 flops to give rx_s. Line-to-rx_s latency is 2 clocks.
- Sample counter (sc): counts clken ticks and advances only when clken=1; every FSM decision below is taken on a clken tick.
- FSM states: IDLE, START, DATA, PARITY (feature only), STOP. rx_busy = (state != IDLE).
- IDLE:
  - If rx_s=0 on a tick: go to START with sc=0.
- START:
  - Increment sc each tick.
  - At the tick where sc==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=0: go to DATA with sc=0 and bit index=0.
  - rx_s=1: glitch; return to IDLE with no flags raised.
- DATA:
  - At sc==OVERSAMPLE-1, shift[bit index] <= rx_s and set sc=0.
  - After bit 7, go to STOP (or PARITY when the feature is enabled); otherwise increment the bit index.
- STOP:
  - At sc==OVERSAMPLE-1, sample rx_s and return to IDLE.
  - rx_s=1: dout <= shift and rdy <= 1. If rdy was already 1 and rdy_clr is not asserted this cycle, pulse overrun; dout is overwritten either way.
  - rx_s=0: pulse frame_err; dout and rdy are unchanged.
- Simultaneous rdy_clr and byte completion: the completion wins, so rdy stays 1 and no overrun pulse is raised.
- rdy_clr with rdy=0: no effect.
- Because the FSM returns to IDLE at mid stop bit, back-to-back frames are received with no dead time.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values. On release, a low rx is treated as a new start bit; resulting garbage is tolerated, as the standard UART resync behaviour.
- Pulse outputs (frame_err, overrun, parity_err) are registered, high for exactly one clk_50m cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit is inserted between DATA and STOP, sampled at sc==OVERSAMPLE-1 in state PARITY.
  - At stop: if the XOR of data bits and parity bit is 1, pulse parity_err; dout and rdy are unchanged.
  - A frame with both a parity mismatch and a low stop bit pulses both parity_err and frame_err.
- Undefined:
  - The PARITY state does not exist and parity_err is constant 0.
  - The port list is identical in both builds.

Decomposition:
- Package uart_pkg: FSM state encoding (shared with the transmitter's IDLE/START/DATA/STOP naming), DEFAULT_OVERSAMPLE=16, DATA_BITS=8.
- Sub-module: uart_sync2, a reusable 2-flop synchronizer with reset value 1, instantiated for rx.
- All other logic stays flat in uart_rx.

Test Plan:
- Test conditions: OVERSAMPLE=16, clken every 27 clocks.
1. Send 0x55 with stop=1 -> rdy rises about 9.5 bit times after the start edge; dout=8'h55; frame_err, overrun and parity_err stay 0; rx_busy falls in the same cycle rdy rises.
2. Drive rx low for 4 clken ticks, then high -> START aborts at mid-bit; rdy stays 0; no flags; rx_busy high for about 8 ticks only.
3. Send 0xA3 with stop=0 after a prior 0x11 (rdy cleared) -> frame_err pulses once; rdy=0; dout stays 8'h11.
4. Send 0x12 then 0x34 back-to-back without rdy_clr -> second completion pulses overrun; dout=8'h34; rdy=1. Repeat with rdy_clr asserted on the exact completion cycle -> rdy=1 and no overrun.
5. Assert rst_n=0 during data bit 3 of a frame -> all outputs reset asynchronously; after release and an idle line, 0xC3 is received correctly.
6. With UART_RX_PARITY_EN defined: send 0x07 with parity=1 -> dout=8'h07, rdy=1. Send 0x07 with parity=0 -> parity_err pulses and rdy is unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e       : frame FSM states (IDLE/START/DATA/[PARITY]/STOP)
//   DEFAULT_OVERSAMPLE : clken ticks per bit period
//   DATA_BITS          : payload bits per frame
// Optional macro UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS          = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: consumer-side bundle of the UART receiver.
//   rdy_clr    : consumer acknowledge, clears rdy
//   dout       : last received byte
//   rdy        : sticky "dout holds an unread byte"
//   rx_busy    : frame in progress
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   overrun    : 1-cycle pulse, byte completed while rdy already set
//   parity_err : 1-cycle pulse, parity mismatch (0 without UART_RX_PARITY_EN)
// Modports: master = consumer, slave = receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rdy_clr;
  logic [DATA_BITS-1:0] dout;
  logic                 rdy;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;

  modport master (
    output rdy_clr,
    input  dout, rdy, rx_busy, frame_err, overrun, parity_err
  );

  modport slave (
    input  rdy_clr,
    output dout, rdy, rx_busy, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level, resets to 1
// so an idle-high serial line never looks like a start bit after reset.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, 2 clocks latency
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled by an external clken tick.
//   clk_50m : system clock
//   rst_n   : asynchronous active-low reset
//   clken   : oversample tick, OVERSAMPLE per bit period
//   rx      : asynchronous serial line, idles high
//   bus     : uart_rx_if.slave (rdy_clr in; dout, rdy, rx_busy, pulses out)
// Parameter OVERSAMPLE: ticks per bit, even and >= 4.
// Optional macro UART_RX_PARITY_EN: even parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic     clk_50m,
  input  logic     rst_n,
  input  logic     clken,
  input  logic     rx,
  uart_rx_if.slave bus
);
  localparam int unsigned     SCW      = $clog2(OVERSAMPLE);
  localparam int unsigned     BW       = $clog2(DATA_BITS);
  localparam logic [SCW-1:0]  SC_MID   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0]  SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [SCW-1:0]       sc_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 rdy_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_s;
  logic                 sc_last_d;
  logic [SCW-1:0]       sc_inc_d;

  uart_sync2 u_sync_rx (
    .clk_i  (clk_50m),
    .rst_ni (rst_n),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign sc_last_d = (sc_q == SC_LAST);
  assign sc_inc_d  = sc_q + SCW'(1);

`ifdef UART_RX_PARITY_EN
  logic par_q;
  logic parity_err_q;
  logic par_bad_d;
  // Even parity: data bits plus parity bit must XOR to 0.
  assign par_bad_d = ^{shift_q, par_q};
`endif

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      rdy_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // A byte completing in this same cycle overrides the clear below.
      if (bus.rdy_clr) rdy_q <= 1'b0;

      if (clken) begin
        case (state_q)
          IDLE: begin
            if (!rx_s) begin
              state_q <= START;
              sc_q    <= '0;
            end
          end
          START: begin
            if (sc_q == SC_MID) begin
              sc_q    <= '0;
              bit_q   <= '0;
              state_q <= rx_s ? IDLE : DATA;
            end else begin
              sc_q <= sc_inc_d;
            end
          end
          DATA: begin
            if (sc_last_d) begin
              sc_q           <= '0;
              shift_q[bit_q] <= rx_s;
              if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end else begin
              sc_q <= sc_inc_d;
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sc_last_d) begin
              sc_q    <= '0;
              par_q   <= rx_s;
              state_q <= STOP;
            end else begin
              sc_q <= sc_inc_d;
            end
          end
`endif
          STOP: begin
            // Leaving at mid stop bit lets a following start edge be caught.
            if (sc_last_d) begin
              sc_q        <= '0;
              state_q     <= IDLE;
              frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_d;
              if (rx_s && !par_bad_d) begin
`else
              if (rx_s) begin
`endif
                dout_q    <= shift_q;
                rdy_q     <= 1'b1;
                overrun_q <= rdy_q & ~bus.rdy_clr;
              end
            end else begin
              sc_q <= sc_inc_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rdy       = rdy_q;
  assign bus.rx_busy   = (state_q != IDLE);
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at OVERSAMPLE=16, clken every 27
// clocks. Each frame pushes its expected end-of-frame outcome; a monitor pops
// one entry whenever rx_busy falls and compares outputs and latency.
// Honours UART_RX_PARITY_EN to match the RTL build.
module tb_uart_rx;
  localparam int OS     = 16;
  localparam int TICKP  = 27;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Tick (counted from the tick before the start edge) of the stop decision.
  localparam int DONE_TICK = (NB - 1) * OS + OS / 2 + 1;

  typedef struct {
    string      name;
    logic [7:0] dout;
    logic       rdy;
    logic       fe;
    logic       ov;
    logic       pe;
    int         t0;
    int         lat;
  } exp_t;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  logic clken   = 1'b0;
  logic rx      = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .clken   (clken),
    .rx      (rx),
    .bus     (bus)
  );

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] m_dout = 8'h00;
  logic       m_rdy  = 1'b0;
  bit         prev_busy = 1'b0;
  exp_t       mon_e;

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc++;

  initial begin
    forever begin
      repeat (TICKP - 1) @(negedge clk_50m);
      clken = 1'b1;
      @(negedge clk_50m);
      clken = 1'b0;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  // Monitor: one expectation per falling edge of rx_busy.
  initial begin
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !bus.rx_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: frame ended at cycle %0d, required no frame end", cyc);
          end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, ".dout"}, 32'(bus.dout), 32'(mon_e.dout));
            chk({mon_e.name, ".rdy"}, 32'(bus.rdy), 32'(mon_e.rdy));
            chk({mon_e.name, ".frame_err"}, 32'(bus.frame_err), 32'(mon_e.fe));
            chk({mon_e.name, ".overrun"}, 32'(bus.overrun), 32'(mon_e.ov));
            chk({mon_e.name, ".parity_err"}, 32'(bus.parity_err), 32'(mon_e.pe));
            chk({mon_e.name, ".latency"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
          end
        end else if (bus.frame_err || bus.overrun || bus.parity_err) begin
          checks++;
          errors++;
          $display("FAIL stray_pulse: fe=%b ov=%b pe=%b at cycle %0d, required 000",
                   bus.frame_err, bus.overrun, bus.parity_err, cyc);
        end
        prev_busy = bus.rx_busy;
      end
    end
  end

  initial begin
    repeat (98000) @(posedge clk_50m);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_50m iff clken);
    #1;
  endtask

  task automatic bit_time(input logic b);
    rx = b;
    repeat (OS) tick();
  endtask

  task automatic clear_rdy();
    bus.rdy_clr = 1'b1;
    @(posedge clk_50m);
    #1 bus.rdy_clr = 1'b0;
    m_rdy = 1'b0;
    chk("rdy_after_clr", 32'(bus.rdy), 32'(m_rdy));
    tick();
  endtask

  function automatic void push(input string nm, input logic fe, ov, pe, input int lat_ticks);
    exp_t e;
    e.name = nm;
    e.dout = m_dout;
    e.rdy  = m_rdy;
    e.fe   = fe;
    e.ov   = ov;
    e.pe   = pe;
    e.t0   = cyc;
    e.lat  = lat_ticks * TICKP;
    exp_q.push_back(e);
  endfunction

  // Called tick-aligned. flip corrupts the parity bit (parity build only);
  // clr_done asserts rdy_clr exactly on the stop-decision cycle.
  task automatic send_frame(input string nm, input logic [7:0] d, input bit stop,
                            input bit flip, input bit clr_done);
    bit par_ok;
    bit ok;
`ifdef UART_RX_PARITY_EN
    par_ok = !flip;
`else
    par_ok = 1'b1;
`endif
    ok = stop && par_ok;
    begin
      logic ov;
      ov = ok && m_rdy && !clr_done;
      if (ok) begin
        m_dout = d;
        m_rdy  = 1'b1;
      end else if (clr_done) begin
        m_rdy = 1'b0;
      end
      push(nm, !stop, ov, !par_ok, DONE_TICK);
    end
    // A low stop bit is seen again as a start edge and aborts at mid-bit.
    if (!stop) push({nm, ".resync"}, 1'b0, 1'b0, 1'b0, DONE_TICK + OS / 2 + 1);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ flip);
`endif
    rx = stop;
    repeat (OS / 2) tick();
    if (clr_done) begin
      repeat (TICKP - 1) @(posedge clk_50m);
      #1 bus.rdy_clr = 1'b1;
      @(posedge clk_50m);
      #1 bus.rdy_clr = 1'b0;
    end else begin
      tick();
    end
    repeat (OS / 2 - 1) tick();
    rx = 1'b1;
    if (!stop) repeat (OS) tick();
  endtask

  initial begin
    bus.rdy_clr = 1'b0;
    repeat (5) @(posedge clk_50m);
    chk("reset.dout", 32'(bus.dout), 32'h00);
    chk("reset.rdy", 32'(bus.rdy), 32'h0);
    chk("reset.rx_busy", 32'(bus.rx_busy), 32'h0);
    chk("reset.pulses", 32'({bus.frame_err, bus.overrun, bus.parity_err}), 32'h0);
    #1 rst_n = 1'b1;
    repeat (2) tick();

    // 1: clean byte
    send_frame("t1_0x55", 8'h55, 1'b1, 1'b0, 1'b0);

    // 2: start-bit glitch of 4 ticks
    push("t2_glitch", 1'b0, 1'b0, 1'b0, OS / 2 + 1);
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (OS + 4) tick();

    // 3: framing error keeps previous byte
    clear_rdy();
    send_frame("t3_0x11", 8'h11, 1'b1, 1'b0, 1'b0);
    clear_rdy();
    clear_rdy();
    send_frame("t3_0xA3_fe", 8'hA3, 1'b0, 1'b0, 1'b0);

    // 4: back-to-back overrun, then clear on the completion cycle
    send_frame("t4_0x12", 8'h12, 1'b1, 1'b0, 1'b0);
    send_frame("t4_0x34_ov", 8'h34, 1'b1, 1'b0, 1'b0);
    send_frame("t4_0x56_ov", 8'h56, 1'b1, 1'b0, 1'b0);
    send_frame("t4_0x78_clr", 8'h78, 1'b1, 1'b0, 1'b1);

    // 5: reset during data bit 3
    rx = 1'b0;
    repeat (OS) tick();
    rx = 1'b1;
    repeat (3 * OS) tick();
    rx = 1'b0;
    repeat (OS / 2) tick();
    #1 rst_n = 1'b0;
    #1;
    chk("midreset.dout", 32'(bus.dout), 32'h00);
    chk("midreset.rdy", 32'(bus.rdy), 32'h0);
    chk("midreset.rx_busy", 32'(bus.rx_busy), 32'h0);
    m_dout = 8'h00;
    m_rdy  = 1'b0;
    rx = 1'b1;
    repeat (3) @(posedge clk_50m);
    #1 rst_n = 1'b1;
    repeat (OS + 4) tick();
    send_frame("t5_0xC3", 8'hC3, 1'b1, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then bad
    send_frame("t6_0x07_par1", 8'h07, 1'b1, 1'b0, 1'b0);
    send_frame("t6_0x07_par0", 8'h07, 1'b1, 1'b1, 1'b0);
`endif

    // Random frames
    for (int n = 0; n < 5; n++) begin
      logic [7:0] d;
      bit stop, flip, clr_done;
      d        = 8'($urandom);
      stop     = ($urandom_range(0, 3) != 0);
      flip     = ($urandom_range(0, 3) == 0);
      clr_done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) clear_rdy();
      send_frame($sformatf("rand%0d", n), d, stop, flip, clr_done);
    end

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
